alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 req0_a, req0_b  input  N each  requester 0 operands.
REQ-007 req0_ctrl  input  4  requester 0 ALU opcode (0000 add, 0001 sub, ...).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same widths and directions as requester 0.
REQ-009 alu_a, alu_b  output  N each  operands to the shared ALU.
REQ-010 alu_ctrl  output  4  opcode to the shared ALU.
REQ-011 alu_result  input  N  combinational result from the shared ALU.
REQ-012 alu_flags  input  4  ALU flags {neg, zero, carry, overflow}, bit 3 down to bit 0.
REQ-013 resp_valid  output  1  response held on the resp_* outputs.
REQ-014 resp_ready  input  1  consumer accepts the response.
REQ-015 resp_id  output  1  requester that owns the response (0 or 1).
REQ-016 resp_result  output  N; resp_flags  output  4  captured ALU outputs.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-019 req0_ready and req1_ready SHALL be asserted only in IDLE, and at most one of them SHALL be high in any cycle.
REQ-020 Arbitration in IDLE: if one valid, grant it; if both valid, grant the requester not granted last; register last_grant updates on each grant.
REQ-021 Acceptance = reqX_valid & reqX_ready at edge T; a, b, ctrl and id SHALL be registered at T and the FSM SHALL move IDLE->EXEC.
REQ-022 ready SHALL be combinational from valid and state: a valid request in IDLE is accepted the same cycle.
REQ-023 In EXEC, alu_a, alu_b and alu_ctrl SHALL come from the operand registers; at the end of EXEC, alu_result and alu_flags SHALL be captured into resp_result and resp_flags, and the FSM SHALL move EXEC->RESP.
REQ-024 resp_valid SHALL rise in the cycle after EXEC; latency from acceptance edge to the first cycle of resp_valid = 2 cycles.
REQ-025 In RESP, resp_valid, resp_id, resp_result and resp_flags SHALL stay stable until resp_valid & resp_ready at an edge, after which the FSM moves RESP->IDLE.
REQ-026 Throughput: at most one operation per 3 cycles; no new request SHALL be accepted in the cycle resp handshakes (ready only in IDLE).
REQ-027 Outside EXEC, alu_a, alu_b and alu_ctrl SHALL hold the last registered values; they have no protocol meaning.
REQ-028 Flags and result SHALL pass through unmodified; no width extension or truncation.
REQ-029 Deasserting reqX_valid before acceptance is permitted; the arbiter SHALL not latch a non-accepted request.

Reset
REQ-030 On rst high, asynchronously: state IDLE, resp_valid 0, busy 0, resp_id 0, resp_result 0, resp_flags 0, operand and ctrl registers 0, last_grant 1 (so requester 0 wins the first tie).
REQ-031 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response for it SHALL appear after reset is released.
REQ-032 The ready outputs SHALL be 0 while rst is high.

Verification
REQ-033 req0 a=10 b=256 ctrl=0000 -> accepted at T; resp_valid at T+2, id 0, result 266, flags 0000.
REQ-034 Both requests in the same cycle: req0 10-10 (0001) and req1 1-10 (0001) -> req0 first with result 0 and zero flag=1; then req1 with result 0xFFFFFFF7, neg=1, zero=0.
REQ-035 Both valid continuously for 4 operations -> grants alternate 0,1,0,1.
REQ-036 req1 24 + (-10) with resp_ready low for 3 cycles -> resp holds result 14 with id 1, stable; both ready outputs stay 0; after the handshake, return to IDLE.
REQ-037 rst pulsed during EXEC -> all outputs reach their reset values immediately; no stale resp_valid; the next request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// Each operation moves through IDLE -> EXEC -> RESP; ties alternate between requesters.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_ctrl,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_ctrl,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_result,
  output logic [3:0]   resp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         grant0;
  logic         grant1;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   op_ctrl;
  logic         op_id;

  // Grants exist only in IDLE; on a tie the requester not granted last wins.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_grant)) begin
          grant0 = 1'b1;
        end else if (req1_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      op_id       <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
    end else begin
      state <= state_nxt;
      // Acceptance edge: latch the winner's operation
      if (grant0 || grant1) begin
        op_a       <= grant1 ? req1_a    : req0_a;
        op_b       <= grant1 ? req1_b    : req0_b;
        op_ctrl    <= grant1 ? req1_ctrl : req0_ctrl;
        op_id      <= grant1;
        last_grant <= grant1;
      end
      // End of EXEC: capture the ALU outputs unmodified
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_flags  <= alu_flags;
        resp_id     <= op_id;
      end
    end
  end

  assign alu_a      = op_a;
  assign alu_b      = op_b;
  assign alu_ctrl   = op_ctrl;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU and scores responses against a queue
// of expected {id, result, flags} entries pushed when requests are driven.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl, alu_flags;
  logic        resp_valid, resp_ready, resp_id, busy;
  logic [31:0] resp_result;
  logic [3:0]  resp_flags;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic [3:0]  fl;
  } sb_t;

  sb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  alu_arbiter #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {neg, zero, carry, overflow, result}
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [32:0] w;
    logic [31:0] r;
    logic        cy;
    logic        ov;
    w  = '0;
    r  = '0;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      4'd0: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[31:0];
        cy = w[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r  = a - b;
        cy = (a < b);
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {r[31], (r == 32'd0), cy, ov, r};
  endfunction

  always_comb {alu_flags, alu_result} = ref_alu(alu_a, alu_b, alu_ctrl);

  function automatic sb_t mk_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] c);
    logic [35:0] v;
    v = ref_alu(a, b, c);
    return '{id: id, res: v[31:0], fl: v[35:32]};
  endfunction

  // An empty queue yields X fields so the following comparison cannot match.
  function automatic sb_t pop_exp();
    sb_t e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL rst_ready got %b want 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({resp_valid, busy, resp_id} !== 3'b000) begin
      errors++; $display("FAIL rst_ctrl got %b want 000", {resp_valid, busy, resp_id});
    end
    checks++;
    if ({resp_result, resp_flags} !== 36'd0) begin
      errors++; $display("FAIL rst_resp got %h want 0", {resp_result, resp_flags});
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== 68'd0) begin
      errors++; $display("FAIL rst_ops got %h want 0", {alu_a, alu_b, alu_ctrl});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie;
    int  cyc;
    sb_t e;
    req0_a = 32'd10; req0_b = 32'd10; req0_ctrl = 4'd1;
    req1_a = 32'd1;  req1_b = 32'd10; req1_ctrl = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 32'd10, 32'd10, 4'd1));
    exp_q.push_back(mk_exp(1'b1, 32'd1, 32'd10, 4'd1));
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL tie_first got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_resp(cyc);
    e = pop_exp();
    checks++;
    if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl}) begin
      errors++; $display("FAIL tie_resp0 got %h want %h", {resp_id, resp_result, resp_flags}, e);
    end
    checks++;
    if (resp_result !== 32'd0 || resp_flags[2] !== 1'b1) begin
      errors++; $display("FAIL tie_zero got %h/%b want 0/zero=1", resp_result, resp_flags);
    end
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_resp got %b want 0", req1_ready);
    end
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL tie_second got %b want 01", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(cyc);
    e = pop_exp();
    checks++;
    if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl}) begin
      errors++; $display("FAIL tie_resp1 got %h want %h", {resp_id, resp_result, resp_flags}, e);
    end
    checks++;
    if (resp_result !== 32'hFFFF_FFF7 || resp_flags[3:2] !== 2'b10) begin
      errors++; $display("FAIL tie_neg got %h/%b want fffffff7/neg=1,zero=0", resp_result, resp_flags);
    end
    @(negedge clk);
  endtask

  task automatic test_alternate;
    int  cyc;
    sb_t e;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_a = 32'd100 + i; req0_b = 32'd3 * i;   req0_ctrl = (i % 2) ? 4'd3 : 4'd0;
      req1_a = 32'd200 + i; req1_b = 32'd7 + i;   req1_ctrl = (i % 2) ? 4'd1 : 4'd2;
      if (i % 2) exp_q.push_back(mk_exp(1'b1, req1_a, req1_b, req1_ctrl));
      else       exp_q.push_back(mk_exp(1'b0, req0_a, req0_b, req0_ctrl));
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL alt_grant op %0d got %b", i, {req0_ready, req1_ready});
      end
      @(negedge clk);
      wait_resp(cyc);
      e = pop_exp();
      checks++;
      if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl}) begin
        errors++; $display("FAIL alt_resp op %0d got %h want %h", i, {resp_id, resp_result, resp_flags}, e);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single;
    sb_t e;
    req0_a = 32'd10; req0_b = 32'd256; req0_ctrl = 4'd0;
    req0_valid = 1'b1; resp_ready = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 32'd10, 32'd256, 4'd0));
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if ({resp_valid, busy} !== 2'b01) begin
      errors++; $display("FAIL single_exec got %b want 01", {resp_valid, busy});
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== {32'd10, 32'd256, 4'd0}) begin
      errors++; $display("FAIL single_ops got %h want 10/256/0", {alu_a, alu_b, alu_ctrl});
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency resp_valid got %b want 1", resp_valid);
    end
    e = pop_exp();
    checks++;
    if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl} ||
        {resp_id, resp_result, resp_flags} !== {1'b0, 32'd266, 4'd0}) begin
      errors++; $display("FAIL single_resp got %h want 0/266/0", {resp_id, resp_result, resp_flags});
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL single_idle got %b want 00", {resp_valid, busy});
    end
  endtask

  task automatic test_backpressure;
    int  cyc;
    sb_t e;
    req1_a = 32'd24; req1_b = 32'hFFFF_FFF6; req1_ctrl = 4'd0;
    req1_valid = 1'b1; resp_ready = 1'b0;
    exp_q.push_back(mk_exp(1'b1, 32'd24, 32'hFFFF_FFF6, 4'd0));
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept got %b want 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(cyc);
    checks++;
    if (cyc != 1) begin
      errors++; $display("FAIL bp_latency got %0d want 1", cyc);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_result, req0_ready, req1_ready} !== {2'b11, 32'd14, 2'b00}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v%b id%b r%0d rdy%b%b want v1 id1 r14 rdy00",
                           k, resp_valid, resp_id, resp_result, req0_ready, req1_ready);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    e = pop_exp();
    checks++;
    if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl}) begin
      errors++; $display("FAIL bp_resp got %h want %h", {resp_id, resp_result, resp_flags}, e);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL bp_idle got %b want 00", {resp_valid, busy});
    end
  endtask

  task automatic test_drop_valid;
    int  cyc;
    sb_t e;
    req1_a = 32'd7; req1_b = 32'd3; req1_ctrl = 4'd4;
    req1_valid = 1'b1; resp_ready = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 32'd7, 32'd3, 4'd4));
    @(negedge clk);
    req1_valid = 1'b0;
    req0_a = 32'hDEAD; req0_b = 32'h1; req0_ctrl = 4'd3; req0_valid = 1'b1;
    wait_resp(cyc);
    req0_valid = 1'b0;
    e = pop_exp();
    checks++;
    if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl}) begin
      errors++; $display("FAIL drop_resp got %h want %h", {resp_id, resp_result, resp_flags}, e);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy, resp_valid, alu_a} !== {2'b00, 32'd7}) begin
        errors++; $display("FAIL drop_nolatch cycle %0d got busy%b v%b a=%h want 0/0/7",
                           k, busy, resp_valid, alu_a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int  cyc;
    sb_t e;
    req0_a = 32'd55; req0_b = 32'd1; req0_ctrl = 4'd0;
    req0_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rm_exec busy got %b want 1", busy);
    end
    rst = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({busy, resp_valid, req0_ready, req1_ready} !== 4'b0000 ||
        {resp_result, resp_flags, alu_a, alu_ctrl} !== 72'd0) begin
      errors++; $display("FAIL rm_async got ctl %b data %h want 0",
                         {busy, resp_valid, req0_ready, req1_ready}, {resp_result, resp_flags, alu_a});
    end
    @(negedge clk);
    req1_valid = 1'b0; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({resp_valid, busy} !== 2'b00) begin
        errors++; $display("FAIL rm_no_stale cycle %0d got %b want 00", k, {resp_valid, busy});
      end
      @(negedge clk);
    end
    req1_a = 32'd5; req1_b = 32'd3; req1_ctrl = 4'd1; req1_valid = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 32'd5, 32'd3, 4'd1));
    @(negedge clk);
    req1_valid = 1'b0;
    wait_resp(cyc);
    checks++;
    if (cyc != 1) begin
      errors++; $display("FAIL rm_next_latency got %0d want 1", cyc);
    end
    e = pop_exp();
    checks++;
    if ({resp_id, resp_result, resp_flags} !== {e.id, e.res, e.fl} || resp_result !== 32'd2) begin
      errors++; $display("FAIL rm_next_resp got %h want %h", {resp_id, resp_result, resp_flags}, e);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_alternate();
    test_single();
    test_backpressure();
    test_drop_valid();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
